// File: rtl/cm_sketch_sched_if.sv
// cm_sketch_sched_if: request/issue bundle between the channel address taps,
// the scheduler and cm_sketch_top.
//   req_valid/req_addr/req_ready : per-requester handshake (requester i at
//                                  req_addr[i*ADDR_SIZE +: ADDR_SIZE])
//   sk_input_valid/sk_input_addr : issue into cm_sketch_top
//   sk_clear_valid/sk_clear_idx  : column clear sweep
//   epoch_done/epoch_cnt/busy    : epoch status
// master = requester side (drives requests, observes everything else)
// slave  = scheduler side
interface cm_sketch_sched_if #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = 28,
  parameter int HASH_SIZE = 4
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         sk_input_valid;
  logic [ADDR_SIZE-1:0]         sk_input_addr;
  logic                         sk_clear_valid;
  logic [HASH_SIZE-1:0]         sk_clear_idx;
  logic                         epoch_done;
  logic [15:0]                  epoch_cnt;
  logic                         busy;

  modport master (
    output req_valid, req_addr,
    input  req_ready, sk_input_valid, sk_input_addr, sk_clear_valid,
           sk_clear_idx, epoch_done, epoch_cnt, busy
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, sk_input_valid, sk_input_addr, sk_clear_valid,
           sk_clear_idx, epoch_done, epoch_cnt, busy
  );
endinterface

// File: rtl/cm_sketch_sched.sv
// cm_sketch_sched: round-robin front end for the count-min sketch.
// Arbitrates NUM_REQ address streams onto one sketch input port with a
// minimum idle gap of ISSUE_GAP cycles between issues. With the macro
// CM_SKETCH_SCHED_EPOCH_EN defined, every EPOCH_LEN accepts it stalls input,
// waits DRAIN_CYCLES, sweeps a clear over all W columns and then resumes;
// without it the epoch outputs are tied to 0.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : cm_sketch_sched_if.slave (requests in, sketch issue/clear out)
module cm_sketch_sched #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_SIZE    = 28,
  parameter int W            = 16,
  parameter int HASH_SIZE    = $clog2(W),
  parameter int ISSUE_GAP    = 1,
  parameter int EPOCH_LEN    = 4096,
  parameter int DRAIN_CYCLES = 8
) (
  input logic clk,
  input logic rst_n,
  cm_sketch_sched_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1 || EPOCH_LEN < 1 || DRAIN_CYCLES < 1 || ISSUE_GAP < 0 ||
      ISSUE_GAP > 15 || (1 << HASH_SIZE) < W) begin : g_bad_cfg
    $error("cm_sketch_sched: unsupported parameter set");
  end

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     win;
  logic [3:0]           gap_cnt;
  logic [NUM_REQ-1:0]   grant;
  logic                 accept;
  logic                 run_ok;      // FSM is in RUN
  logic                 leave_clear; // last clear cycle; RUN starts with gap 0
  logic                 skv_q;
  logic [ADDR_SIZE-1:0] skaddr_q;
  logic                 found;
  int                   j;

  // First valid requester at or after rr_ptr, wrapping. Gated by rst_n so
  // no grant is shown while reset is asserted.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    j     = 0;
    if (rst_n && run_ok && gap_cnt == 4'd0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (int'(rr_ptr) + k) % NUM_REQ;
        if (!found && bus.req_valid[j]) begin
          found = 1'b1;
          win   = PTR_W'(j);
        end
      end
      if (found) grant[win] = 1'b1;
    end
  end

  assign accept         = |grant;
  assign bus.req_ready  = grant;
  assign bus.sk_input_valid = skv_q;
  assign bus.sk_input_addr  = skaddr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      gap_cnt  <= '0;
      skv_q    <= 1'b0;
      skaddr_q <= '0;
    end else begin
      skv_q <= accept;
      if (accept) begin
        skaddr_q <= bus.req_addr[win*ADDR_SIZE +: ADDR_SIZE];
        rr_ptr   <= (win == PTR_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
        gap_cnt  <= 4'(ISSUE_GAP);
      end else if (leave_clear) begin
        gap_cnt <= '0;
      end else if (gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

`ifdef CM_SKETCH_SCHED_EPOCH_EN
  localparam int ACC_W = $clog2(EPOCH_LEN+1);
  localparam int DRN_W = $clog2(DRAIN_CYCLES+1);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc_cnt;
  logic [DRN_W-1:0] drain_cnt;
  logic             clr_v;
  logic [HASH_SIZE-1:0] clr_idx;
  logic             done_q;
  logic [15:0]      ecnt;

  assign run_ok      = (state == RUN);
  assign leave_clear = (state == CLEAR) && (clr_idx == HASH_SIZE'(W-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      acc_cnt   <= '0;
      drain_cnt <= '0;
      clr_v     <= 1'b0;
      clr_idx   <= '0;
      done_q    <= 1'b0;
      ecnt      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        RUN: if (accept) begin
          // The epoch-closing accept is still issued; DRAIN starts next cycle.
          if (acc_cnt == ACC_W'(EPOCH_LEN-1)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
          acc_cnt <= acc_cnt + 1'b1;
        end
        DRAIN: begin
          if (drain_cnt == DRN_W'(DRAIN_CYCLES-1)) begin
            state   <= CLEAR;
            clr_v   <= 1'b1;
            clr_idx <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        CLEAR: begin
          if (leave_clear) begin
            state   <= RUN;
            clr_v   <= 1'b0;
            clr_idx <= '0;
            done_q  <= 1'b1;
            ecnt    <= ecnt + 1'b1;
            acc_cnt <= '0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.sk_clear_valid = clr_v;
  assign bus.sk_clear_idx   = clr_idx;
  assign bus.epoch_done     = done_q;
  assign bus.epoch_cnt      = ecnt;
  assign bus.busy           = (state != RUN);
`else
  assign run_ok             = 1'b1;
  assign leave_clear        = 1'b0;
  assign bus.sk_clear_valid = 1'b0;
  assign bus.sk_clear_idx   = '0;
  assign bus.epoch_done     = 1'b0;
  assign bus.epoch_cnt      = '0;
  assign bus.busy           = 1'b0;
`endif
endmodule
